// File: rtl/ti_share_encoder.sv
// ti_share_encoder: splits plain X/Y/Z words into 3-share Boolean masks for the TI Toffoli gadget,
// consuming one fresh 2*WIDTH random word per variable through a ready/valid handshake.
module ti_share_encoder #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   X_i,
    input  logic [WIDTH-1:0]   Y_i,
    input  logic [WIDTH-1:0]   Z_i,
    input  logic               rnd_valid_i,
    output logic               rnd_ready_o,
    input  logic [2*WIDTH-1:0] rnd_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   X1_o,
    output logic [WIDTH-1:0]   X2_o,
    output logic [WIDTH-1:0]   X3_o,
    output logic [WIDTH-1:0]   Y1_o,
    output logic [WIDTH-1:0]   Y2_o,
    output logic [WIDTH-1:0]   Y3_o,
    output logic [WIDTH-1:0]   Z1_o,
    output logic [WIDTH-1:0]   Z2_o,
    output logic [WIDTH-1:0]   Z3_o
);
    typedef enum logic [2:0] {IDLE, RX, RY, RZ, OUT} state_t;
    state_t           state;
    logic [WIDTH-1:0] x_q, y_q, z_q;
    logic [WIDTH-1:0] r0, r1;
    logic             rnd_fire;
    assign r0       = rnd_i[WIDTH-1:0];
    assign r1       = rnd_i[2*WIDTH-1:WIDTH];
    assign rnd_fire = rnd_valid_i && rnd_ready_o;
    // Every port is a flop so no plain or random value can glitch through to the share outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b0;
            rnd_ready_o <= 1'b0;
            out_valid_o <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            X1_o        <= '0;
            X2_o        <= '0;
            X3_o        <= '0;
            Y1_o        <= '0;
            Y2_o        <= '0;
            Y3_o        <= '0;
            Z1_o        <= '0;
            Z2_o        <= '0;
            Z3_o        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        x_q         <= X_i;
                        y_q         <= Y_i;
                        z_q         <= Z_i;
                        in_ready_o  <= 1'b0;
                        rnd_ready_o <= 1'b1;
                        state       <= RX;
                    end else begin
                        in_ready_o  <= 1'b1;
                    end
                end
                RX: if (rnd_fire) begin
                    X1_o  <= r0;
                    X2_o  <= r1;
                    X3_o  <= x_q ^ r0 ^ r1;
                    x_q   <= '0;
                    state <= RY;
                end
                RY: if (rnd_fire) begin
                    Y1_o  <= r0;
                    Y2_o  <= r1;
                    Y3_o  <= y_q ^ r0 ^ r1;
                    y_q   <= '0;
                    state <= RZ;
                end
                RZ: if (rnd_fire) begin
                    Z1_o        <= r0;
                    Z2_o        <= r1;
                    Z3_o        <= z_q ^ r0 ^ r1;
                    z_q         <= '0;
                    rnd_ready_o <= 1'b0;
                    out_valid_o <= 1'b1;
                    state       <= OUT;
                end
                OUT: if (out_ready_i) begin
                    // Shares are wiped once consumed so no randomness lingers into the next transaction.
                    X1_o        <= '0;
                    X2_o        <= '0;
                    X3_o        <= '0;
                    Y1_o        <= '0;
                    Y2_o        <= '0;
                    Y3_o        <= '0;
                    Z1_o        <= '0;
                    Z2_o        <= '0;
                    Z3_o        <= '0;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ti_share_encoder.sv
// tb_ti_share_encoder: randomized scoreboard bench for ti_share_encoder, closing the loop
// through a 3-share TI Toffoli model so recombined C must equal (X&Y)^Z.
module tb_ti_share_encoder;
    localparam int W = 8;
    logic clk, rst_i, in_valid_i, in_ready_o, rnd_valid_i, rnd_ready_o, out_valid_o, out_ready_i;
    logic [W-1:0] X_i, Y_i, Z_i;
    logic [2*W-1:0] rnd_i;
    logic [W-1:0] X1_o, X2_o, X3_o, Y1_o, Y2_o, Y3_o, Z1_o, Z2_o, Z3_o;
    logic [8:0][W-1:0] act;
    typedef struct {
        logic [8:0][W-1:0] s;
        logic [W-1:0]      x, y, z;
        int                acc;
        bit                lat;
    } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0, sent = 0, done = 0;
    bit bp_force = 0, rand_bp = 0;

    ti_share_encoder #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .X_i(X_i), .Y_i(Y_i), .Z_i(Z_i), .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o),
        .rnd_i(rnd_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .X1_o(X1_o), .X2_o(X2_o), .X3_o(X3_o), .Y1_o(Y1_o), .Y2_o(Y2_o), .Y3_o(Y3_o),
        .Z1_o(Z1_o), .Z2_o(Z2_o), .Z3_o(Z3_o)
    );
    assign act = {Z3_o, Z2_o, Z1_o, Y3_o, Y2_o, Y1_o, X3_o, X2_o, X1_o};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer readiness changes well away from both clock edges.
    initial forever begin
        @(posedge clk);
        #2;
        out_ready_i = bp_force ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, a, e, cyc);
        end
    endtask

    // Shares after the first n variables are encoded; the rest stay zero.
    function automatic logic [8:0][W-1:0] enc(input logic [W-1:0] x, y, z,
                                              input logic [2*W-1:0] ra, rb, rc, input int n);
        logic [2:0][W-1:0]   v;
        logic [2:0][2*W-1:0] r;
        logic [8:0][W-1:0]   s;
        v = {z, y, x};
        r = {rc, rb, ra};
        s = '0;
        for (int i = 0; i < n; i++) begin
            s[3*i]   = r[i][W-1:0];
            s[3*i+1] = r[i][2*W-1:W];
            s[3*i+2] = v[i] ^ r[i][W-1:0] ^ r[i][2*W-1:W];
        end
        return s;
    endfunction

    // Three-share TI Toffoli: each output share omits one input share index; returns C1^C2^C3.
    function automatic logic [W-1:0] tof(input logic [8:0][W-1:0] s);
        logic [W-1:0] c1, c2, c3;
        c1 = (s[1] & s[4]) ^ (s[1] & s[5]) ^ (s[2] & s[4]) ^ s[7];
        c2 = (s[2] & s[5]) ^ (s[0] & s[5]) ^ (s[2] & s[3]) ^ s[8];
        c3 = (s[0] & s[3]) ^ (s[0] & s[4]) ^ (s[1] & s[3]) ^ s[6];
        return c1 ^ c2 ^ c3;
    endfunction

    initial begin
        bit   prev;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_i) prev = 0;
            else begin
                if (out_valid_o && !prev) begin
                    if (q.size() == 0) chk("spurious_out_valid", 1, 0);
                    else if (q[0].lat) chk("latency", cyc, q[0].acc + 4);
                end
                if (out_valid_o && q.size() != 0) begin
                    chk("shares", act, q[0].s);
                    chk("plain_zero_in_out", {dut.x_q, dut.y_q, dut.z_q}, 0);
                end
                if (out_valid_o && out_ready_i && q.size() != 0) begin
                    e = q.pop_front();
                    chk("toffoli_closure", tof(act), (e.x & e.y) ^ e.z);
                    done++;
                end
                chk("in_ready_vs_out_valid", in_ready_o && out_valid_o, 0);
                prev = out_valid_o;
            end
        end
    end

    task automatic send(input logic [W-1:0] x, y, z, input logic [2*W-1:0] ra, rb, rc,
                        input int sb, input int sn, input bit bp, input bit abort, input bit lat);
        logic [2*W-1:0] r[3];
        exp_t e;
        int t, acc;
        r[0] = ra; r[1] = rb; r[2] = rc;
        @(negedge clk);
        in_valid_i = 1; X_i = x; Y_i = y; Z_i = z;
        t = 0;
        while (!in_ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_accept_timeout", in_ready_o, 1);
        if (!in_ready_o) begin
            in_valid_i = 0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        if (bp) bp_force = 1;
        in_valid_i = 0; X_i = W'($urandom); Y_i = W'($urandom); Z_i = W'($urandom);
        for (int b = 0; b < 3; b++) begin
            if (abort && b == 2) begin
                rst_i = 0; rnd_valid_i = 0;
                #1;
                chk("abort_ctrl", {in_ready_o, rnd_ready_o, out_valid_o}, 0);
                chk("abort_shares", act, 0);
                chk("abort_plain", {dut.x_q, dut.y_q, dut.z_q}, 0);
                @(negedge clk);
                rst_i = 1;
                @(negedge clk);
                chk("abort_in_ready", in_ready_o, 1);
                bp_force = 0;
                return;
            end
            if (b == sb) begin
                repeat (sn) begin
                    rnd_valid_i = 0; rnd_i = 2*W'($urandom);
                    chk("stall_shares", act, enc(x, y, z, ra, rb, rc, b));
                    chk("stall_rnd_ready", rnd_ready_o, 1);
                    @(negedge clk);
                end
            end
            rnd_valid_i = 1; rnd_i = r[b];
            t = 0;
            while (!rnd_ready_o && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("rnd_ready_timeout", rnd_ready_o, 1);
            if (!rnd_ready_o) begin
                rnd_valid_i = 0; bp_force = 0;
                return;
            end
            if (b == 2) begin
                e.s = enc(x, y, z, ra, rb, rc, 3); e.x = x; e.y = y; e.z = z; e.acc = acc; e.lat = lat;
                q.push_back(e);
                sent++;
            end
            @(negedge clk);
        end
        rnd_valid_i = 0;
        if (bp) begin
            repeat (10) begin
                in_valid_i = 1; X_i = W'($urandom); Y_i = W'($urandom); Z_i = W'($urandom);
                chk("bp_in_ready", in_ready_o, 0);
                chk("bp_out_valid", out_valid_o, 1);
                @(negedge clk);
            end
            in_valid_i = 0; bp_force = 0;
        end
    endtask

    initial begin
        int t;
        rst_i = 0; in_valid_i = 0; rnd_valid_i = 0; X_i = 0; Y_i = 0; Z_i = 0; rnd_i = 0;
        out_ready_i = 1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {in_ready_o, rnd_ready_o, out_valid_o}, 0);
        chk("rst_shares", act, 0);
        chk("rst_plain", {dut.x_q, dut.y_q, dut.z_q}, 0);
        rst_i = 1;
        #1;
        chk("in_ready_before_edge", in_ready_o, 0);
        @(negedge clk);
        chk("in_ready_after_edge", in_ready_o, 1);
        send(8'hA5, 8'h3C, 8'h0F, 16'h1122, 16'h3344, 16'h5566, 3, 0, 0, 0, 1);
        send(8'h5A, 8'hC3, 8'hF0, 16'hDEAD, 16'hBEEF, 16'h0123, 1, 5, 0, 0, 0);
        send(8'hFF, 8'h00, 8'h81, 16'hAAAA, 16'h5555, 16'hF00F, 3, 0, 1, 0, 0);
        send(8'h12, 8'h34, 8'h56, 16'h789A, 16'hBCDE, 16'hF012, 3, 0, 0, 1, 0);
        send(8'hA5, 8'h3C, 8'h0F, 16'h1122, 16'h3344, 16'h5566, 3, 0, 0, 0, 1);
        rand_bp = 1;
        repeat (1000)
            send(W'($urandom), W'($urandom), W'($urandom), 2*W'($urandom), 2*W'($urandom),
                 2*W'($urandom), $urandom_range(0, 5), $urandom_range(1, 4), 0, 0, 0);
        t = 0;
        while ((q.size() != 0 || out_valid_o) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        chk("completed_count", done, sent);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ti_share_encoder.md
TI_SHARE_ENCODER -- requirements
Module: ti_share_encoder

Purpose: converts plain X/Y/Z words into the 3-share Boolean masking consumed by the team's 3-share TI Toffoli gadget (C = X&Y ^ Z), drawing fresh randomness through a handshake.

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of every data and share word.
REQ-002 Port clk_i, input, 1 bit, SHALL be the single clock; all state is updated on its rising edge.
REQ-003 Port rst_i, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port in_valid_i, input, 1 bit, SHALL mark valid plain operands.
REQ-005 Port in_ready_o, output, 1 bit, SHALL signal that plain operands can be accepted.
REQ-006 Ports X_i, Y_i, Z_i, input, WIDTH bits each, SHALL carry the plain operands.
REQ-007 Port rnd_valid_i, input, 1 bit, SHALL mark a valid random word.
REQ-008 Port rnd_ready_o, output, 1 bit, SHALL request a random word.
REQ-009 Port rnd_i, input, 2*WIDTH bits, SHALL carry the random word: r0 in the low half, r1 in the high half.
REQ-010 Port out_valid_o, output, 1 bit, SHALL mark valid shares.
REQ-011 Port out_ready_i, input, 1 bit, SHALL signal that the consumer accepts the shares.
REQ-012 Ports X1_o..X3_o, Y1_o..Y3_o, Z1_o..Z3_o, output, WIDTH bits each, SHALL carry the shares.

Function
REQ-013 The FSM SHALL have states IDLE, RX, RY, RZ and OUT.
REQ-014 IDLE: in_ready_o=1; when in_valid_i&&in_ready_o, the block SHALL latch X_i, Y_i, Z_i into internal plain registers and go to RX.
REQ-015 RX/RY/RZ: rnd_ready_o=1; on rnd_valid_i&&rnd_ready_o, the block SHALL write the current variable's shares (V1=r0, V2=r1, V3=V^r0^r1) and advance RX->RY->RZ->OUT.
REQ-016 Without rnd_valid_i, the FSM SHALL stall in its current state with all registers unchanged.
REQ-017 Each random word SHALL be used for exactly one variable; random words SHALL never be reused or held across transactions.
REQ-018 After its shares are written, each plain register SHALL be cleared to 0 in the same cycle (zeroization).
REQ-019 OUT: out_valid_o=1; all nine share outputs SHALL hold stable until out_valid_o&&out_ready_i, then the FSM SHALL go to IDLE.
REQ-020 out_valid_o SHALL rise on the cycle after the third random word is accepted; minimum latency from input acceptance to out_valid_o is 4 cycles.
REQ-021 in_ready_o SHALL be 1 only in IDLE; inputs offered in any other state SHALL be ignored.
REQ-022 rnd_ready_o SHALL be 1 only in RX/RY/RZ.
REQ-023 Every output SHALL be driven directly from a register, with no combinational path from X_i/Y_i/Z_i or rnd_i to any output (glitch isolation).
REQ-024 Share XOR SHALL be bitwise, WIDTH bits wide, with no carry.
REQ-025 Share registers SHALL update only on accepted random beats, so shares of unprocessed variables read 0 during encoding.

Reset
REQ-026 While rst_i=0, the FSM SHALL be in IDLE and all plain and share registers SHALL be 0.
REQ-027 While rst_i=0: out_valid_o=0, rnd_ready_o=0, in_ready_o=0.
REQ-028 in_ready_o SHALL first be 1 on the first clock edge after rst_i deasserts.
REQ-029 Reset asserted mid-transaction (any of RX..OUT) SHALL abort the transaction and zero all state asynchronously; no partial shares SHALL be output afterwards.

Verification
REQ-030 Basic encode: X=0xA5, Y=0x3C, Z=0x0F; rnd beats {r1,r0} = {0x11,0x22}, {0x33,0x44}, {0x55,0x66}, back-to-back -> out_valid_o 4 cycles after input acceptance; X1=0x22, X2=0x11, X3=0x96; Y1=0x44, Y2=0x33, Y3=0x4B; Z1=0x66, Z2=0x55, Z3=0x3C.
REQ-031 Randomness stall: hold rnd_valid_i=0 for 5 cycles in RY -> state and shares unchanged; after the beat, completion occurs with correct shares.
REQ-032 Output backpressure: out_ready_i=0 for 10 cycles -> shares stable; in_ready_o=0; new in_valid_i ignored.
REQ-033 Reset mid-RZ: rst_i low for 1 cycle -> all outputs 0, FSM in IDLE; the next transaction encodes correctly.
REQ-034 Randomized closure: 1000 random transactions feeding the encoder into the TI Toffoli gadget -> XOR of C shares == (X&Y)^Z every time; plain registers read 0 in OUT.
